// File: rtl/fdtd_pkg.sv
// fdtd_pkg: shared constants, types and arithmetic helpers for the H-field
// update engine.
//   W_DEF / FRAC_DEF : default word width and coefficient fractional bits
//   wide_t           : wide signed scratch type used by the helpers so that
//                      products and sums never overflow before saturation
//   tag_t            : per-stage pipeline tag (valid, start/end of line)
//   sat_w            : clamp a value to the signed range of 'width' bits
//   round_cut        : add one half LSB and arithmetic-shift right by 'frac'
//   lane_lo          : low bit index of lane k in a packed multi-lane bus
package fdtd_pkg;

  localparam int W_DEF    = 32;
  localparam int FRAC_DEF = 21;
  localparam int CW       = 128;

  typedef logic signed [CW-1:0] wide_t;

  typedef struct packed {
    logic vld;
    logic sol;
    logic eol;
  } tag_t;

  function automatic wide_t sat_w(input wide_t value, input int width);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (width - 1));
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end else begin
      return value;
    end
  endfunction

  // Round half up: the bias moves exact halves to the next integer toward
  // +infinity, then the arithmetic shift floors.
  function automatic wide_t round_cut(input wide_t product, input int frac);
    wide_t bias;
    bias = wide_t'(1) <<< (frac - 1);
    return (product + bias) >>> frac;
  endfunction

  function automatic int lane_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/fdtd_calc_h_lanes_mul_cut.sv
// fdtd_mul_cut: registered signed multiply followed by a registered
// round-half-up cut and saturation to W bits.
//   CLK, RST : clock, asynchronous active-high reset
//   ce       : advance enable; both stages hold when low
//   a        : W-bit signed coefficient
//   b        : (W+1)-bit signed operand
//   y        : W-bit rounded and saturated result (two cycles after a/b)
//   sat      : high when y was clamped
module fdtd_mul_cut
  import fdtd_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                ce,
  input  logic signed [W-1:0] a,
  input  logic signed [W:0]   b,
  output logic signed [W-1:0] y,
  output logic                sat
);

  // W x (W+1) signed product needs 2W+1 bits and cannot overflow.
  logic signed [2*W:0] prod;
  wide_t               prod_x;
  wide_t               cut;
  wide_t               lim;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prod <= '0;
    end else if (ce) begin
      prod <= (2*W+1)'(a) * (2*W+1)'(b);
    end
  end

  assign prod_x = wide_t'(prod);
  assign cut    = round_cut(prod_x, FRAC);
  assign lim    = sat_w(cut, W);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      y   <= '0;
      sat <= 1'b0;
    end else if (ce) begin
      y   <= lim[W-1:0];
      sat <= (lim != cut);
    end
  end

endmodule

// File: rtl/fdtd_calc_h_lanes.sv
// fdtd_calc_h_lanes: NCH-lane H-field update
//   H_new = chh*H_old + che*(E_i - E_prev)   (signed fixed point, FRAC bits)
// Four-stage pipeline, one beat per cycle, whole pipeline stalls together.
//   CLK, RST             : clock, asynchronous active-high reset
//   in_valid/in_ready    : input beat handshake
//   in_sol/in_eol        : line start (forces E_prev=0) / line end tag
//   h_old,e_cur,chh,che  : per-lane operands, lane k at [k*W +: W]
//   mode_neg             : 0 -> E_i - E_prev, 1 -> E_prev - E_i
//   out_valid/out_ready  : output beat handshake
//   out_sol/out_eol      : tags aligned with h_new
//   h_new                : per-lane result
//   sat_flag / sat_clr   : sticky per-lane saturation flag and its clear
//
// Handshake: a beat moves on a rising edge when valid & ready. in_ready is
// the global advance (out_ready | ~out_valid); when it is low every stage
// holds its contents, so a presented output stays stable until taken.
module fdtd_calc_h_lanes
  import fdtd_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int FRAC = FRAC_DEF,
  parameter int NCH  = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sol,
  input  logic             in_eol,
  input  logic [NCH*W-1:0] h_old,
  input  logic [NCH*W-1:0] e_cur,
  input  logic [NCH*W-1:0] chh,
  input  logic [NCH*W-1:0] che,
  input  logic             mode_neg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sol,
  output logic             out_eol,
  output logic [NCH*W-1:0] h_new,
  output logic [NCH-1:0]   sat_flag,
  input  logic             sat_clr
);

  logic adv;
  logic acc;
  tag_t t1, t2, t3;

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;
  assign acc      = in_valid & adv;

  // Tags are masked with valid so a bubble never carries a stray sol/eol.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      t1        <= '0;
      t2        <= '0;
      t3        <= '0;
      out_valid <= 1'b0;
      out_sol   <= 1'b0;
      out_eol   <= 1'b0;
    end else if (adv) begin
      t1        <= '{vld: in_valid, sol: in_valid & in_sol, eol: in_valid & in_eol};
      t2        <= t1;
      t3        <= t2;
      out_valid <= t3.vld;
      out_sol   <= t3.sol;
      out_eol   <= t3.eol;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    localparam int LO = lane_lo(k, W);

    logic signed [W-1:0] e_in;
    logic signed [W-1:0] e_prev;
    logic signed [W-1:0] prev_eff;
    logic signed [W:0]   diff;
    logic signed [W:0]   d1;
    logic signed [W-1:0] h1;
    logic signed [W-1:0] chh1;
    logic signed [W-1:0] che1;
    logic signed [W:0]   h1x;
    logic signed [W-1:0] ye;
    logic signed [W-1:0] yh;
    logic                se;
    logic                sh;
    logic signed [W:0]   sum;
    wide_t               sum_x;
    wide_t               sum_v;
    logic                sum_sat;
    logic signed [W-1:0] h_r;
    logic                flag_r;

    assign e_in = e_cur[LO +: W];

    // Stage 1 operand: difference in W+1 bits so it can never wrap.
    always_comb begin
      prev_eff = in_sol ? '0 : e_prev;
      diff     = '0;
      if (mode_neg) begin
        diff = (W+1)'(prev_eff) - (W+1)'(e_in);
      end else begin
        diff = (W+1)'(e_in) - (W+1)'(prev_eff);
      end
    end

    // E_prev only follows accepted beats; bubbles and stalls leave it alone.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        e_prev <= '0;
      end else if (acc) begin
        e_prev <= e_in;
      end
    end

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        d1   <= '0;
        h1   <= '0;
        chh1 <= '0;
        che1 <= '0;
      end else if (adv) begin
        d1   <= diff;
        h1   <= h_old[LO +: W];
        chh1 <= chh[LO +: W];
        che1 <= che[LO +: W];
      end
    end

    assign h1x = {h1[W-1], h1};

    // Stages 2 and 3 live inside the multiplier blocks.
    fdtd_mul_cut #(.W(W), .FRAC(FRAC)) u_mul_e (
      .CLK (CLK),
      .RST (RST),
      .ce  (adv),
      .a   (che1),
      .b   (d1),
      .y   (ye),
      .sat (se)
    );

    fdtd_mul_cut #(.W(W), .FRAC(FRAC)) u_mul_h (
      .CLK (CLK),
      .RST (RST),
      .ce  (adv),
      .a   (chh1),
      .b   (h1x),
      .y   (yh),
      .sat (sh)
    );

    // Stage 4: add the two cut terms and clamp.
    always_comb begin
      sum     = (W+1)'(ye) + (W+1)'(yh);
      sum_x   = wide_t'(sum);
      sum_v   = sat_w(sum_x, W);
      sum_sat = (sum_v != sum_x);
    end

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        h_r <= '0;
      end else if (adv) begin
        h_r <= sum_v[W-1:0];
      end
    end

    // A set on the same edge as sat_clr wins; only valid beats can set it.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        flag_r <= 1'b0;
      end else begin
        flag_r <= (sat_clr ? 1'b0 : flag_r) | (adv & t3.vld & (se | sh | sum_sat));
      end
    end

    assign h_new[LO +: W] = h_r;
    assign sat_flag[k]    = flag_r;
  end

endmodule

// File: tb/tb_fdtd_calc_h_lanes.sv
module tb_fdtd_calc_h_lanes;

  localparam int W    = 32;
  localparam int FRAC = 21;
  localparam int NCH  = 4;
  localparam int VW   = NCH * W;

  // Coefficients in Q(32-21).21
  localparam int ONE    = 2097152;
  localparam int HALF   = 1048576;
  localparam int TWO    = 4194304;
  localparam int M_ONE  = -2097152;
  localparam int M_HALF = -1048576;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic          in_valid, in_ready, in_sol, in_eol, mode_neg;
  logic [VW-1:0] h_old, e_cur, chh, che, h_new;
  logic          out_valid, out_ready, out_sol, out_eol, sat_clr;
  logic [NCH-1:0] sat_flag;

  fdtd_calc_h_lanes #(.W(W), .FRAC(FRAC), .NCH(NCH)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sol    (in_sol),
    .in_eol    (in_eol),
    .h_old     (h_old),
    .e_cur     (e_cur),
    .chh       (chh),
    .che       (che),
    .mode_neg  (mode_neg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sol   (out_sol),
    .out_eol   (out_eol),
    .h_new     (h_new),
    .sat_flag  (sat_flag),
    .sat_clr   (sat_clr)
  );

  // ---------------- scoreboard state ----------------
  logic [VW+1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int rst_count = 0;
  bit hold  = 0;
  bit bp_en = 0;
  int bp_idx = 0;
  logic [3:0] pat = 4'b1001;

  function automatic logic [VW-1:0] rep(input int x);
    return {x, x, x, x};
  endfunction

  function automatic logic [VW-1:0] lanes4(input int a0, input int a1, input int a2, input int a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge CLK);
    in_valid  = 1'b0;
    out_ready = hold ? 1'b0 : (bp_en ? pat[bp_idx % 4] : 1'b1);
    bp_idx++;
  endtask

  task automatic send(input bit sol, input bit eol, input bit mode,
                      input logic [VW-1:0] h, input logic [VW-1:0] e,
                      input logic [VW-1:0] ch, input logic [VW-1:0] ce,
                      input logic [VW-1:0] ex);
    bit ok;
    int n;
    ok = 0;
    n  = 0;
    while (!ok && n < 100) begin
      tick();
      in_valid = 1'b1;
      in_sol   = sol;
      in_eol   = eol;
      mode_neg = mode;
      h_old    = h;
      e_cur    = e;
      chh      = ch;
      che      = ce;
      #1;
      ok = in_ready;
      @(posedge CLK);
      n++;
    end
    if (ok) begin
      exp_q.push_back({sol, eol, ex});
    end else begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: %0d outputs outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    #3;
  endtask

  // ---------------- monitor ----------------
  task automatic monitor();
    logic [VW+1:0] exp;
    logic [VW+1:0] held;
    bit was_stall;
    int seen_rst;
    was_stall = 0;
    seen_rst  = 0;
    held      = '0;
    forever begin
      @(negedge CLK);
      #2;
      if (seen_rst != rst_count) begin
        was_stall = 0;
        seen_rst  = rst_count;
      end
      if (was_stall) begin
        total++;
        if (out_valid !== 1'b1 || {out_sol, out_eol, h_new} !== held) begin
          bad++;
          $display("FAIL stall_hold: valid=%0b data=%h required valid=1 data=%h",
                   out_valid, {out_sol, out_eol, h_new}, held);
        end
      end
      was_stall = 0;
      if (out_valid && !out_ready) begin
        total++;
        if (in_ready !== 1'b0) begin
          bad++;
          $display("FAIL in_ready_stall: got %0b required 0", in_ready);
        end
        was_stall = 1;
        held      = {out_sol, out_eol, h_new};
      end
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output: got h_new=%h with empty queue", h_new);
        end else begin
          exp = exp_q.pop_front();
          if ({out_sol, out_eol, h_new} !== exp) begin
            bad++;
            $display("FAIL output: got sol=%0b eol=%0b h_new=%h required sol=%0b eol=%0b h_new=%h",
                     out_sol, out_eol, h_new, exp[VW+1], exp[VW], exp[VW-1:0]);
          end
        end
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    RST = 1'b1;
    in_valid = 1'b0; in_sol = 1'b0; in_eol = 1'b0; mode_neg = 1'b0;
    h_old = '0; e_cur = '0; chh = '0; che = '0;
    out_ready = 1'b1; sat_clr = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #2;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_h_new", 128'(h_new), 128'(0));
    check("rst_sat_flag", 128'(sat_flag), 128'(0));
    check("rst_tags", 128'({out_sol, out_eol}), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));

    fork
      monitor();
    join_none

    // Basic Hy with 4-cycle latency and a bubble gap between beats.
    send(1, 0, 0, rep(100), rep(10), rep(ONE), rep(HALF), rep(105));
    for (int i = 1; i <= 4; i++) begin
      tick();
      #2;
      check("latency_valid", 128'(out_valid), 128'(i == 4));
    end
    send(0, 1, 0, rep(100), rep(30), rep(ONE), rep(HALF), rep(110));
    drain();

    // Rounding: +3 -> 2, -3 -> -1, then mode_neg gives 13-10=3 -> 2.
    send(1, 0, 0, rep(0), rep(3),  rep(0), rep(HALF), rep(2));
    send(0, 0, 0, rep(0), rep(0),  rep(0), rep(HALF), rep(-1));
    send(0, 0, 0, rep(0), rep(13), rep(0), rep(HALF), rep(7));
    send(0, 1, 1, rep(0), rep(10), rep(0), rep(HALF), rep(2));
    drain();
    check("no_sat_yet", 128'(sat_flag), 128'(0));

    // Positive saturation, sticky flag, clear, negative mirror.
    send(1, 1, 0, rep(32'h7FFF_FFF0), rep(32'h0000_0100), rep(ONE), rep(ONE), rep(32'h7FFF_FFFF));
    drain();
    check("sat_pos_flag", 128'(sat_flag), 128'(4'hF));
    send(1, 1, 0, rep(5), rep(1), rep(ONE), rep(ONE), rep(6));
    drain();
    check("sat_sticky", 128'(sat_flag), 128'(4'hF));
    tick();
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    #2;
    check("sat_cleared", 128'(sat_flag), 128'(0));
    send(1, 1, 0, rep(32'h8000_0010), rep(32'hFFFF_FF00), rep(ONE), rep(ONE), rep(32'h8000_0000));
    drain();
    check("sat_neg_flag", 128'(sat_flag), 128'(4'hF));

    // Backpressure: out_ready follows 1,0,0,1; outputs are the diffs 1..8.
    bp_en = 1;
    bp_idx = 0;
    send(1, 0, 0, rep(0), rep(1),  rep(0), rep(ONE), rep(1));
    send(0, 0, 0, rep(0), rep(3),  rep(0), rep(ONE), rep(2));
    send(0, 0, 0, rep(0), rep(6),  rep(0), rep(ONE), rep(3));
    send(0, 0, 0, rep(0), rep(10), rep(0), rep(ONE), rep(4));
    send(0, 0, 0, rep(0), rep(15), rep(0), rep(ONE), rep(5));
    send(0, 0, 0, rep(0), rep(21), rep(0), rep(ONE), rep(6));
    send(0, 0, 0, rep(0), rep(28), rep(0), rep(ONE), rep(7));
    send(0, 1, 0, rep(0), rep(36), rep(0), rep(ONE), rep(8));
    drain();
    bp_en = 0;

    // Independent lanes, two lines of three beats.
    send(1, 0, 0, lanes4(100, 40, 0, 7), lanes4(5, 1, 9, 0),
         lanes4(ONE, HALF, 0, M_ONE), lanes4(ONE, TWO, HALF, M_HALF), lanes4(105, 22, 5, -7));
    send(0, 0, 0, lanes4(100, 40, 0, 7), lanes4(8, 4, 2, 10),
         lanes4(ONE, HALF, 0, M_ONE), lanes4(ONE, TWO, HALF, M_HALF), lanes4(103, 26, -3, -12));
    send(0, 1, 0, lanes4(100, 40, 0, 7), lanes4(20, 2, 7, 10),
         lanes4(ONE, HALF, 0, M_ONE), lanes4(ONE, TWO, HALF, M_HALF), lanes4(112, 16, 3, -7));
    send(1, 0, 0, lanes4(100, 40, 0, 7), lanes4(3, 6, -4, 100),
         lanes4(ONE, HALF, 0, M_ONE), lanes4(ONE, TWO, HALF, M_HALF), lanes4(103, 32, -2, -57));
    send(0, 0, 0, lanes4(100, 40, 0, 7), lanes4(1, 6, -5, 50),
         lanes4(ONE, HALF, 0, M_ONE), lanes4(ONE, TWO, HALF, M_HALF), lanes4(98, 20, 0, 18));
    send(0, 1, 0, lanes4(100, 40, 0, 7), lanes4(4, 0, 0, 51),
         lanes4(ONE, HALF, 0, M_ONE), lanes4(ONE, TWO, HALF, M_HALF), lanes4(103, 8, 3, -7));
    drain();

    // Asynchronous reset while an output is stalled; flags still set.
    hold = 1;
    send(1, 0, 0, rep(0), rep(500), rep(ONE), rep(ONE), rep(500));
    send(0, 0, 0, rep(0), rep(600), rep(ONE), rep(ONE), rep(100));
    repeat (4) tick();
    #2;
    check("stall_before_reset", 128'(out_valid), 128'(1));
    @(posedge CLK);
    #3;
    RST = 1'b1;
    rst_count++;
    #1;
    check("async_rst_valid", 128'(out_valid), 128'(0));
    check("async_rst_sat", 128'(sat_flag), 128'(0));
    check("async_rst_h_new", 128'(h_new), 128'(0));
    exp_q.delete();
    @(negedge CLK);
    RST = 1'b0;
    hold = 0;
    // No sol on this beat: E_prev must already be 0 after the reset.
    send(0, 1, 0, rep(0), rep(10), rep(ONE), rep(ONE), rep(10));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fdtd_calc_h_lanes.md
Name: fdtd_calc_h_lanes

Overview:
- Parametrised, multi-lane H-field update engine for the FDTD accelerator. Successor to the single-channel Hy kernel.
- Per lane it computes H_new = chh*H_old + che*(E_i - E_prev) in signed fixed point, with round-half-up cut and saturation.
- Mode select gives Hx sign. Boundary (PEC) handling is at start-of-line. A valid/ready stream with full-pipeline stall carries the data.
- Sits between the field-memory read streamer and the H write-back streamer.

Parameters:
- W, 32, field/coefficient word width (signed two's complement).
- FRAC, 21, fractional bits of coefficients; product cut = bits [FRAC+W-1:FRAC] plus sign, then saturated.
- NCH, 4, number of parallel lanes (independent grid lines).

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  engine can accept beat
- in_sol  in  1  first sample of a line (all lanes)
- in_eol  in  1  last sample of a line (pass-through tag)
- h_old  in  NCH*W  previous H per lane, lane k at [k*W +: W]
- e_cur  in  NCH*W  E at current index per lane
- chh  in  NCH*W  H self-coefficient per lane
- che  in  NCH*W  E-curl coefficient per lane
- mode_neg  in  1  0: diff = E_i - E_prev (Hy); 1: diff = E_prev - E_i (Hx); sampled per beat
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_sol  out  1  delayed in_sol
- out_eol  out  1  delayed in_eol
- h_new  out  NCH*W  updated H per lane
- sat_flag  out  NCH  sticky per-lane saturation indicator
- sat_clr  in  1  synchronous clear of sat_flag

Behaviour:
- Reset (RST high, async): all pipeline valid bits 0, E_prev registers 0, out_valid=0, out_sol=out_eol=0, h_new=0, sat_flag=0.
- Advance: adv = out_ready | ~out_valid. in_ready = adv, combinational. When adv=0 every stage holds.
- Input beat accepted when in_valid & in_ready.
- Latency: 4 cycles accept-to-out_valid with no stall; throughput 1 beat/cycle.
- Stage 1:
  - diff = e_cur - E_prev, or negated if mode_neg. Width W+1, cannot overflow.
  - E_prev <= e_cur on accept only.
  - If in_sol, E_prev is treated as 0 for this beat (PEC boundary).
  - h_old, chh, che and the tags are registered.
- Stage 2: p_e = che*diff (2W+1 bits); p_h = chh*h_old (2W bits).
- Stage 3: each product: add 2^(FRAC-1), arithmetic shift right by FRAC, saturate to [-2^(W-1), 2^(W-1)-1].
- Stage 4: sum the two W-bit terms in W+1 bits and saturate to W. Drives h_new, out_sol, out_eol.
- Saturation: any saturation event in stage 3 or 4 of lane k sets sat_flag[k] when that beat is in a valid, advancing stage.
- sat_clr: clears the flags. If a set and sat_clr coincide, the set wins.
- Invalid bubbles: never update E_prev or sat_flag.
- Lane independence: lanes never interact. mode_neg, sol and eol are shared across lanes.
- Mid-line reset: line state is lost. The next beat is expected to carry in_sol; otherwise E_prev=0 is used anyway.
- Stall with out_valid=1: h_new and tags stay stable until out_ready.

Decomposition:
- Package fdtd_pkg holds:
  - Default W/FRAC constants.
  - Functions sat_w(value, width) and round_cut(product, frac).
  - Lane-slice helper.
- Sub-module fdtd_mul_cut: one registered multiply plus round/saturate. Two pipeline stages; CE = adv. Outputs the W-bit result and a sat bit. Instantiated 2*NCH times.

Test Plan:
- Coefficient values: 1.0 = 0x0020_0000, 0.5 = 0x0010_0000.
- Basic Hy (W=32, FRAC=21, lane 0): chh=1.0, che=0.5, h_old=100. Beats e_cur=10 (sol), 30 -> h_new=105, then 110. out_valid 4 cycles after each accept.
- Rounding: chh=0, che=0.5, diff=+3 -> 2; diff=-3 -> -1 (round half up). mode_neg=1 with e_cur=10 after 13 gives diff=+3 -> 2.
- Saturation: chh=1.0, che=1.0, h_old=0x7FFF_FFF0, diff=0x100 -> h_new=0x7FFF_FFFF, sat_flag[0]=1 sticky. sat_clr -> 0. Negative mirror -> 0x8000_0000.
- Backpressure: stream 8 beats with out_ready toggled 1,0,0,1 repeating -> all 8 outputs in order, none duplicated or lost. h_new held stable during each stall. in_ready low while out_valid & ~out_ready.
- Lanes/boundary (NCH=4): distinct per-lane coefficients, two lines of 3 beats each. E_prev resets at second sol -> per-lane results match the reference model. out_sol/out_eol align with the first and last outputs.
- Async reset mid-stream: assert RST for 1 cycle between clock edges -> out_valid=0 immediately, sat_flag=0. Next line computes from E_prev=0.
